multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Control unit for a multicycle 32-bit MIPS datapath.
- A Moore main FSM sequences fetch/decode/execute/memory/writeback steps from the 6-bit opcode.
- A combinational ALU decoder turns a 2-bit aluop and the 6-bit funct into the 3-bit ALU control.
- Sits beside the datapath: takes op/funct from the instruction register and zero from the ALU; drives every mux select and write enable.

Parameters:
- none

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; forces FSM to FETCH
- op  in  6  instr[31:26]
- funct  in  6  instr[5:0]
- zero  in  1  ALU result == 0
- pcen  out  1  PC write enable = pcwrite | (branch & zero)
- memwrite  out  1  memory write enable
- irwrite  out  1  instruction register load
- regwrite  out  1  register file write enable
- alusrca  out  1  0 = PC, 1 = register A
- iord  out  1  0 = PC address, 1 = ALUOut address
- memtoreg  out  1  0 = ALUOut, 1 = data register
- regdst  out  1  0 = rt, 1 = rd
- alusrcb  out  2  00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = immediate<<2
- pcsrc  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- alucontrol  out  3  ALU operation

Behaviour:
- Interface: one clock clk; reset is synchronous and active-high.
- State register updates on posedge clk. reset=1 at an edge gives state FETCH, overriding any transition, including mid-instruction.
- All outputs are a combinational function of the state (plus zero for pcen, funct for alucontrol). Any signal not listed for a state is 0; pcsrc, alusrcb and aluop default to 00.
- Opcodes: lw 100011, sw 101011, R-type 000000, beq 000100, addi 001000, j 000010.
- FSM states, asserted outputs and next state:
  - FETCH: irwrite, pcwrite, alusrcb=01 -> DECODE
  - DECODE: alusrcb=11 -> by op: lw/sw MEMADR, R-type RTYPEEX, beq BEQEX, addi ADDIEX, j JEX, any other op FETCH
  - MEMADR: alusrca, alusrcb=10 -> lw MEMRD, sw MEMWR
  - MEMRD: iord -> MEMWB
  - MEMWB: regwrite, memtoreg -> FETCH
  - MEMWR: iord, memwrite -> FETCH
  - RTYPEEX: alusrca, aluop=10 -> RTYPEWB
  - RTYPEWB: regwrite, regdst -> FETCH
  - BEQEX: alusrca, branch, pcsrc=01, aluop=01 -> FETCH
  - ADDIEX: alusrca, alusrcb=10 -> ADDIWB
  - ADDIWB: regwrite -> FETCH
  - JEX: pcwrite, pcsrc=10 -> FETCH
  - Unused state encodings -> FETCH, with all outputs 0.
- Latencies, fetch to next fetch: lw 5 cycles; sw, R-type and addi 4; beq and j 3.
- ALU decoder:
  - aluop 00 -> 010 (add); 01 -> 110 (sub); 11 -> 010.
  - aluop 10 decodes funct: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111, any other funct -> 010.
- pcen in BEQEX follows zero combinationally. In all states except FETCH and JEX, pcen = branch & zero, which is 0 outside BEQEX.

Decomposition:
- Shared package:
  - state enum (4-bit, FETCH = 0)
  - opcode constants
  - funct constants
  - aluop encodings
  - alucontrol encodings
- One sub-module: alu_decoder (aluop, funct -> alucontrol).
- FSM and the pcen logic stay in the top-level module.

Test Plan:
- reset=1 for 2 cycles, then op=001000 (addi 0x20020005) -> FETCH (irwrite=1, pcen=1, alusrcb=01, alucontrol=010), DECODE (alusrcb=11), ADDIEX (alusrca=1, alusrcb=10), ADDIWB (regwrite=1, regdst=0, memtoreg=0), then FETCH.
- R-type or 0x00e22025 -> RTYPEEX alucontrol=001, then RTYPEWB regwrite=1, regdst=1. Repeat for and (000), add 0x00a42820 (010), sub 0x00e23822 (110), slt (111).
- sw 0xac670044 -> MEMADR (alusrca=1, alusrcb=10), MEMWR (iord=1, memwrite=1), back to FETCH after 4 cycles total; regwrite stays 0 throughout.
- lw 0x8c020050 -> MEMADR, MEMRD (iord=1, memwrite=0), MEMWB (regwrite=1, memtoreg=1, regdst=0); 5 cycles total.
- beq op=000100: zero=0 -> BEQEX pcen=0, pcsrc=01, alucontrol=110. zero=1 -> pcen=1. j op=000010 -> JEX pcen=1, pcsrc=10. Both return to FETCH.
- Reset asserted in RTYPEEX -> FETCH on the next edge, regwrite never asserted. Illegal op 111111 -> DECODE then FETCH.

Source files
------------

// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle MIPS controller: FSM states, opcodes,
// R-type funct codes, ALU-decoder op classes and ALU control values.
package multicycle_controller_pkg;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JEX     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] ALUCTL_AND = 3'b000;
    localparam logic [2:0] ALUCTL_OR  = 3'b001;
    localparam logic [2:0] ALUCTL_ADD = 3'b010;
    localparam logic [2:0] ALUCTL_SUB = 3'b110;
    localparam logic [2:0] ALUCTL_SLT = 3'b111;

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// ALU decoder: maps the FSM's aluop class plus the R-type funct field to the
// 3-bit ALU operation. Purely combinational.
module multicycle_controller_alu_decoder
    import multicycle_controller_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [5:0] funct,
    output logic [2:0] alucontrol
);

    // Non-R-type classes pick add/sub directly; R-type decodes funct, falling back to add.
    always_comb begin
        alucontrol = ALUCTL_ADD;
        case (aluop)
            ALUOP_ADD: alucontrol = ALUCTL_ADD;
            ALUOP_SUB: alucontrol = ALUCTL_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FUNCT_ADD: alucontrol = ALUCTL_ADD;
                    FUNCT_SUB: alucontrol = ALUCTL_SUB;
                    FUNCT_AND: alucontrol = ALUCTL_AND;
                    FUNCT_OR:  alucontrol = ALUCTL_OR;
                    FUNCT_SLT: alucontrol = ALUCTL_SLT;
                    default:   alucontrol = ALUCTL_ADD;
                endcase
            end
            default: alucontrol = ALUCTL_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS control unit: Moore main FSM that steps each instruction
// through fetch/decode/execute/memory/writeback, plus the PC enable and the
// ALU decoder. All outputs depend on the state only, except pcen (zero) and
// alucontrol (funct).
module multicycle_controller
    import multicycle_controller_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pcen,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic       alusrca,
    output logic       iord,
    output logic       memtoreg,
    output logic       regdst,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol
);

    state_t     state_q;
    state_t     state_d;
    logic       pcwrite;
    logic       branch;
    logic [1:0] aluop;

    // State register; reset wins over any transition, even mid-instruction.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and Moore outputs; everything defaults to 0 / 00.
    always_comb begin
        state_d  = FETCH;
        pcwrite  = 1'b0;
        branch   = 1'b0;
        memwrite = 1'b0;
        irwrite  = 1'b0;
        regwrite = 1'b0;
        alusrca  = 1'b0;
        iord     = 1'b0;
        memtoreg = 1'b0;
        regdst   = 1'b0;
        alusrcb  = 2'b00;
        pcsrc    = 2'b00;
        aluop    = ALUOP_ADD;
        case (state_q)
            FETCH: begin
                irwrite = 1'b1;
                pcwrite = 1'b1;
                alusrcb = 2'b01;
                state_d = DECODE;
            end
            DECODE: begin
                alusrcb = 2'b11;
                case (op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = RTYPEEX;
                    OP_BEQ:       state_d = BEQEX;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JEX;
                    default:      state_d = FETCH;
                endcase
            end
            MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                if (op == OP_LW) begin
                    state_d = MEMRD;
                end else if (op == OP_SW) begin
                    state_d = MEMWR;
                end else begin
                    state_d = FETCH;
                end
            end
            MEMRD: begin
                iord    = 1'b1;
                state_d = MEMWB;
            end
            MEMWB: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
                state_d  = FETCH;
            end
            MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
                state_d  = FETCH;
            end
            RTYPEEX: begin
                alusrca = 1'b1;
                aluop   = ALUOP_FUNCT;
                state_d = RTYPEWB;
            end
            RTYPEWB: begin
                regwrite = 1'b1;
                regdst   = 1'b1;
                state_d  = FETCH;
            end
            BEQEX: begin
                alusrca = 1'b1;
                branch  = 1'b1;
                pcsrc   = 2'b01;
                aluop   = ALUOP_SUB;
                state_d = FETCH;
            end
            ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = ADDIWB;
            end
            ADDIWB: begin
                regwrite = 1'b1;
                state_d  = FETCH;
            end
            JEX: begin
                pcwrite = 1'b1;
                pcsrc   = 2'b10;
                state_d = FETCH;
            end
            default: state_d = FETCH;
        endcase
    end

    // The branch path lets the ALU's zero flag gate the PC write in BEQEX.
    assign pcen = pcwrite | (branch & zero);

    multicycle_controller_alu_decoder u_alu_decoder (
        .aluop      (aluop),
        .funct      (funct),
        .alucontrol (alucontrol)
    );

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: per-instruction step plans produce the
// expected control word for every cycle, compared against the DUT outputs.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] op = 6'd0;
    logic [5:0] funct = 6'd0;
    logic       zero = 1'b0;
    logic       pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg, regdst;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;

    int checks = 0;
    int errors = 0;

    // Control word: {pcen,memwrite,irwrite,regwrite,alusrca,iord,memtoreg,regdst,alusrcb,pcsrc,alucontrol}
    logic [14:0] obs;
    logic [14:0] exp_q[$];
    logic [14:0] got_q[$];

    typedef enum int {
        P_IFETCH, P_IDECODE, P_ADDR, P_LOAD, P_LOADWB, P_STORE,
        P_ALU, P_ALUWB, P_BRANCH, P_IMM, P_IMMWB, P_JUMP
    } step_t;

    multicycle_controller dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .pcen       (pcen),
        .memwrite   (memwrite),
        .irwrite    (irwrite),
        .regwrite   (regwrite),
        .alusrca    (alusrca),
        .iord       (iord),
        .memtoreg   (memtoreg),
        .regdst     (regdst),
        .alusrcb    (alusrcb),
        .pcsrc      (pcsrc),
        .alucontrol (alucontrol)
    );

    assign obs = {pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg, regdst,
                  alusrcb, pcsrc, alucontrol};

    always #5 clk = ~clk;

    // ALU operation an R-type instruction should request.
    function automatic logic [2:0] rtype_alu(input logic [5:0] f);
        case (f)
            6'h20:   return 3'b010;
            6'h22:   return 3'b110;
            6'h24:   return 3'b000;
            6'h25:   return 3'b001;
            6'h2a:   return 3'b111;
            default: return 3'b010;
        endcase
    endfunction

    // Expected control word for one step of an instruction.
    function automatic logic [14:0] ref_word(input step_t s, input logic z, input logic [5:0] f);
        logic p, mw, ir, rw, sa, io, mr, rd;
        logic [1:0] sb, ps;
        logic [2:0] ac;
        p = 0; mw = 0; ir = 0; rw = 0; sa = 0; io = 0; mr = 0; rd = 0;
        sb = 2'b00; ps = 2'b00; ac = 3'b010;
        case (s)
            P_IFETCH:  begin ir = 1; p = 1; sb = 2'b01; end
            P_IDECODE: sb = 2'b11;
            P_ADDR:    begin sa = 1; sb = 2'b10; end
            P_LOAD:    io = 1;
            P_LOADWB:  begin rw = 1; mr = 1; end
            P_STORE:   begin io = 1; mw = 1; end
            P_ALU:     begin sa = 1; ac = rtype_alu(f); end
            P_ALUWB:   begin rw = 1; rd = 1; end
            P_BRANCH:  begin sa = 1; p = z; ps = 2'b01; ac = 3'b110; end
            P_IMM:     begin sa = 1; sb = 2'b10; end
            P_IMMWB:   rw = 1;
            P_JUMP:    begin p = 1; ps = 2'b10; end
            default:   ;
        endcase
        return {p, mw, ir, rw, sa, io, mr, rd, sb, ps, ac};
    endfunction

    // Driver: plays one instruction from FETCH back to the next FETCH,
    // queueing expected and observed words. zmode 0/1 forces zero, 2 randomizes.
    // Entry/exit point: just after a negedge with the DUT in FETCH.
    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int zmode);
        step_t st[$];
        logic  zq[$];
        logic  z;
        st.push_back(P_IFETCH);
        st.push_back(P_IDECODE);
        case (o)
            6'b100011: begin st.push_back(P_ADDR); st.push_back(P_LOAD); st.push_back(P_LOADWB); end
            6'b101011: begin st.push_back(P_ADDR); st.push_back(P_STORE); end
            6'b000000: begin st.push_back(P_ALU); st.push_back(P_ALUWB); end
            6'b000100: st.push_back(P_BRANCH);
            6'b001000: begin st.push_back(P_IMM); st.push_back(P_IMMWB); end
            6'b000010: st.push_back(P_JUMP);
            default:   ;
        endcase
        foreach (st[i]) begin
            z = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
            zq.push_back(z);
            exp_q.push_back(ref_word(st[i], z, f));
        end
        op    = o;
        funct = f;
        for (int i = 0; i < st.size(); i++) begin
            if (i > 0) @(negedge clk);
            zero = zq[i];
            #1;
            got_q.push_back(obs);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clk);
        zero = 1'b1;
        #1;
        checks++;
        if (obs !== ref_word(P_IFETCH, 1'b1, 6'd0)) begin
            errors++;
            $display("FAIL reset_cycle1: got %h expected %h", obs, ref_word(P_IFETCH, 1'b1, 6'd0));
        end
        @(negedge clk);
        zero = 1'b0;
        #1;
        checks++;
        if (obs !== ref_word(P_IFETCH, 1'b0, 6'd0)) begin
            errors++;
            $display("FAIL reset_cycle2: got %h expected %h", obs, ref_word(P_IFETCH, 1'b0, 6'd0));
        end
        reset = 1'b0;
    endtask

    task automatic test_addi();
        logic [14:0] e, g;
        run_instr(6'b001000, 6'h05, 2);
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL addi step %0d: got %h expected %h", i, g, e);
            end
        end
    endtask

    task automatic test_rtype();
        logic [5:0]  fl[5];
        logic [14:0] e, g;
        fl = '{6'h25, 6'h24, 6'h20, 6'h22, 6'h2a};
        foreach (fl[k]) begin
            run_instr(6'b000000, fl[k], 2);
            for (int i = 0; exp_q.size() > 0; i++) begin
                e = exp_q.pop_front();
                g = got_q.pop_front();
                checks++;
                if (g !== e) begin
                    errors++;
                    $display("FAIL rtype funct=%b step %0d: got %h expected %h", fl[k], i, g, e);
                end
            end
        end
    endtask

    task automatic test_mem();
        logic [14:0] e, g;
        run_instr(6'b101011, 6'h04, 2);
        run_instr(6'b100011, 6'h10, 2);
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL sw_lw step %0d: got %h expected %h", i, g, e);
            end
        end
    endtask

    task automatic test_branch_jump();
        logic [14:0] e, g;
        run_instr(6'b000100, 6'h00, 0);
        run_instr(6'b000100, 6'h00, 1);
        run_instr(6'b000010, 6'h00, 2);
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL beq_j step %0d: got %h expected %h", i, g, e);
            end
        end
    endtask

    // Reset lands while an R-type is executing; the writeback must never happen.
    task automatic test_reset_mid();
        logic [14:0] e;
        op    = 6'b000000;
        funct = 6'h25;
        zero  = 1'b0;
        #1;
        checks++;
        e = ref_word(P_IFETCH, 1'b0, 6'h25);
        if (obs !== e) begin
            errors++;
            $display("FAIL reset_mid fetch: got %h expected %h", obs, e);
        end
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        e = ref_word(P_ALU, 1'b0, 6'h25);
        if (obs !== e) begin
            errors++;
            $display("FAIL reset_mid execute: got %h expected %h", obs, e);
        end
        reset = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        e = ref_word(P_IFETCH, 1'b0, 6'h25);
        if (obs !== e || regwrite !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid refetch: got %h expected %h", obs, e);
        end
        reset = 1'b0;
    endtask

    task automatic test_illegal();
        logic [14:0] e, g;
        run_instr(6'b111111, 6'h00, 2);
        run_instr(6'b000001, 6'h2a, 2);
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL illegal step %0d: got %h expected %h", i, g, e);
            end
        end
    endtask

    task automatic test_random();
        logic [5:0]  ops[7];
        logic [5:0]  fs[6];
        logic [5:0]  o, f;
        logic [14:0] e, g;
        ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010, 6'b011111};
        fs  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h3f};
        for (int n = 0; n < 60; n++) begin
            o = ops[$urandom_range(0, 6)];
            if ($urandom_range(0, 7) == 0) o = 6'($urandom);
            f = fs[$urandom_range(0, 5)];
            if ($urandom_range(0, 3) == 0) f = 6'($urandom);
            run_instr(o, f, 2);
            for (int i = 0; exp_q.size() > 0; i++) begin
                e = exp_q.pop_front();
                g = got_q.pop_front();
                checks++;
                if (g !== e) begin
                    errors++;
                    $display("FAIL random n=%0d op=%b funct=%b step %0d: got %h expected %h",
                             n, o, f, i, g, e);
                end
            end
        end
        zero = 1'b0;
        #1;
        checks++;
        e = ref_word(P_IFETCH, 1'b0, f);
        if (obs !== e) begin
            errors++;
            $display("FAIL random final_fetch: got %h expected %h", obs, e);
        end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_rtype();
        test_mem();
        test_branch_jump();
        test_reset_mid();
        test_illegal();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
